// File: rtl/gray_wr_pkg.sv
// Shared constants for the gray-plane frame-buffer write scheduler:
// FSM encoding, frame geometry defaults and buffer base addresses.
package gray_wr_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_WAIT_VS = 3'd0;
    localparam state_t S_CAPT    = 3'd1;
    localparam state_t S_REQ     = 3'd2;
    localparam state_t S_DATA    = 3'd3;
    localparam state_t S_DONE    = 3'd4;

    localparam int DEF_IMG_W     = 640;
    localparam int DEF_IMG_H     = 480;
    localparam int DEF_BURST_LEN = 64;

    localparam int WORDS_PER_FRAME  = DEF_IMG_W * DEF_IMG_H / 2;
    localparam int BURSTS_PER_FRAME = WORDS_PER_FRAME / DEF_BURST_LEN;

    localparam logic [23:0] BUF0_BASE_DEF = 24'h000000;
    localparam logic [23:0] BUF1_BASE_DEF = 24'h040000;

    function automatic int words_per_frame(input int w, input int h);
        return w * h / 2;
    endfunction

    function automatic int bursts_per_frame(input int w, input int h,
                                            input int bl);
        return w * h / (2 * bl);
    endfunction

endpackage

// File: rtl/gray_wr_if.sv
// Pixel-in and burst-write-out bundle; master is the scheduler,
// slave is the converter/memory-controller side.
interface gray_wr_if #(
    parameter int ADDR_W = 24
) ();

    logic              pix_vsync;
    logic              pix_de;
    logic [7:0]        pix_y;
    logic              wr_req;
    logic              wr_ack;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic              wr_buf;
    logic              rd_buf;
    logic              frame_done;
    logic              err_ovf;
    logic              err_short;

    modport master (
        input  pix_vsync, pix_de, pix_y, wr_ack, wr_ready,
        output wr_req, wr_addr, wr_data, wr_valid,
        output wr_buf, rd_buf, frame_done, err_ovf, err_short
    );

    modport slave (
        output pix_vsync, pix_de, pix_y, wr_ack, wr_ready,
        input  wr_req, wr_addr, wr_data, wr_valid,
        input  wr_buf, rd_buf, frame_done, err_ovf, err_short
    );

endinterface

// File: rtl/sync_fifo_w16.sv
// Show-ahead 16-bit FIFO with occupancy count and synchronous flush.
// Pushes while full and pops while empty are ignored.
module sync_fifo_w16 #(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [15:0]              i_din,
    input  logic                     i_pop,
    output logic [15:0]              o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full & ~i_flush;
    assign w_pop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/gray_frame_wr_sched.sv
// Captures the Y plane, packs two pixels per word and bursts each frame
// into ping-pong buffers, swapping buffers only after a clean frame.
module gray_frame_wr_sched
    import gray_wr_pkg::*;
#(
    parameter int                IMG_W       = DEF_IMG_W,
    parameter int                IMG_H       = DEF_IMG_H,
    parameter int                BURST_LEN   = DEF_BURST_LEN,
    parameter int                FIFO_DEPTH  = 256,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BUF0_BASE   = ADDR_W'(BUF0_BASE_DEF),
    parameter logic [ADDR_W-1:0] BUF1_BASE   = ADDR_W'(BUF1_BASE_DEF),
    parameter int                SKIP_FRAMES = 2
) (
    input  logic      clk,
    input  logic      rst,
    gray_wr_if.master bus
);

    localparam int WPF  = words_per_frame(IMG_W, IMG_H);
    localparam int BPF  = bursts_per_frame(IMG_W, IMG_H, BURST_LEN);
    localparam int NPIX = 2 * WPF;
    localparam int PW   = $clog2(NPIX + 1);
    localparam int BW   = $clog2(BPF + 1);
    localparam int LW   = $clog2(BURST_LEN);
    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int SW   = $clog2(SKIP_FRAMES + 2);

    logic          r_vs_d;
    logic [SW-1:0] r_skip;
    logic          r_armed;
    logic [PW-1:0] r_pix_cnt;
    logic [7:0]    r_hi;
    logic          r_push;
    logic [15:0]   r_word;

    state_t        r_state;
    logic [BW-1:0] r_burst;
    logic [LW-1:0] r_beat;
    logic          r_zfill;
    logic          r_dirty;
    logic          r_wr_buf;
    logic          r_rd_buf;
    logic          r_frame_done;
    logic          r_err_ovf;
    logic          r_err_short;

    logic              w_vs_rise;
    logic              w_skipping;
    logic              w_start;
    logic              w_pix_ok;
    logic              w_push;
    logic              w_ovf;
    logic              w_valid;
    logic              w_xfer;
    logic              w_pop;
    logic              w_last_beat;
    logic [15:0]       w_dout;
    logic [CW-1:0]     w_count;
    logic              w_full;
    logic              w_empty;
    logic [ADDR_W-1:0] w_base;

    assign w_vs_rise  = bus.pix_vsync & ~r_vs_d;
    assign w_skipping = (r_skip < SW'(SKIP_FRAMES));
    assign w_start    = w_vs_rise & ~w_skipping;
    assign w_pix_ok   = r_armed & bus.pix_de & ~w_start &
                        (r_pix_cnt < PW'(NPIX));

    // A frame start discards a word still in flight from the old frame.
    assign w_push = r_push & ~w_start;
    assign w_ovf  = w_push & w_full;

    assign w_valid     = (r_state == S_DATA) & (r_zfill | ~w_empty);
    assign w_xfer      = w_valid & bus.wr_ready;
    assign w_pop       = w_xfer & ~r_zfill;
    assign w_last_beat = w_xfer & (r_beat == LW'(BURST_LEN - 1));

    assign w_base = r_wr_buf ? BUF1_BASE : BUF0_BASE;

    sync_fifo_w16 #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (w_start),
        .i_push  (w_push),
        .i_din   (r_word),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vs_d    <= 1'b0;
            r_skip    <= '0;
            r_armed   <= 1'b0;
            r_pix_cnt <= '0;
            r_hi      <= '0;
            r_push    <= 1'b0;
            r_word    <= '0;
        end else begin
            r_vs_d <= bus.pix_vsync;
            r_push <= 1'b0;
            if (w_vs_rise && w_skipping)
                r_skip <= r_skip + 1'b1;
            if (w_start) begin
                r_armed   <= 1'b1;
                r_pix_cnt <= '0;
            end else if (w_pix_ok) begin
                r_pix_cnt <= r_pix_cnt + 1'b1;
                if (!r_pix_cnt[0]) begin
                    r_hi <= bus.pix_y;
                end else begin
                    r_word <= {r_hi, bus.pix_y};
                    r_push <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_WAIT_VS;
            r_burst      <= '0;
            r_beat       <= '0;
            r_zfill      <= 1'b0;
            r_dirty      <= 1'b0;
            r_wr_buf     <= 1'b0;
            r_rd_buf     <= 1'b1;
            r_frame_done <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_short  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_ovf) begin
                r_err_ovf <= 1'b1;
                r_dirty   <= 1'b1;
            end
            if (w_xfer)
                r_beat <= w_last_beat ? '0 : r_beat + 1'b1;

            unique case (r_state)
                S_WAIT_VS: begin
                    if (w_start) begin
                        r_state <= S_CAPT;
                        r_burst <= '0;
                        r_dirty <= 1'b0;
                    end
                end
                S_CAPT: begin
                    if (w_start) begin
                        r_err_short <= 1'b1;
                        r_burst     <= '0;
                        r_dirty     <= 1'b0;
                    end else if (w_count >= CW'(BURST_LEN)) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_start) begin
                        r_err_short <= 1'b1;
                        r_burst     <= '0;
                        r_dirty     <= 1'b0;
                        r_state     <= S_CAPT;
                    end else if (bus.wr_ack) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_start) begin
                        r_err_short <= 1'b1;
                        r_burst     <= '0;
                        r_dirty     <= 1'b0;
                        // Pad the granted burst with zeros to its full length.
                        if (w_last_beat) begin
                            r_zfill <= 1'b0;
                            r_state <= S_CAPT;
                        end else begin
                            r_zfill <= 1'b1;
                        end
                    end else if (w_last_beat) begin
                        r_zfill <= 1'b0;
                        if (r_zfill) begin
                            r_state <= S_CAPT;
                        end else if (r_burst == BW'(BPF - 1)) begin
                            r_burst <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_burst <= r_burst + 1'b1;
                            r_state <= S_CAPT;
                        end
                    end
                end
                S_DONE: begin
                    if (!r_dirty) begin
                        r_frame_done <= 1'b1;
                        r_rd_buf     <= r_wr_buf;
                        r_wr_buf     <= ~r_wr_buf;
                    end
                    if (w_start) begin
                        r_dirty <= 1'b0;
                        r_state <= S_CAPT;
                    end else begin
                        r_state <= S_WAIT_VS;
                    end
                end
                default: r_state <= S_WAIT_VS;
            endcase
        end
    end

    assign bus.wr_req     = (r_state == S_REQ);
    assign bus.wr_addr    = w_base + ADDR_W'(r_burst) * ADDR_W'(BURST_LEN);
    assign bus.wr_data    = ((r_state == S_DATA) && !r_zfill) ? w_dout : 16'h0000;
    assign bus.wr_valid   = w_valid;
    assign bus.wr_buf     = r_wr_buf;
    assign bus.rd_buf     = r_rd_buf;
    assign bus.frame_done = r_frame_done;
    assign bus.err_ovf    = r_err_ovf;
    assign bus.err_short  = r_err_short;

endmodule
